// File: rtl/mppt_po_controller.sv
// Perturb-and-observe MPPT sequencer: samples V and I over a shared sense
// port, forms P = V*I and nudges the PWM duty toward the maximum power point.
module mppt_po_controller #(
    parameter int DW         = 8,
    parameter int STEP       = 4,
    parameter int DUTY_MIN   = 16,
    parameter int DUTY_MAX   = 240,
    parameter int DUTY_INIT  = 128,
    parameter int SETTLE_CYC = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic [DW-1:0]   sample_in,
    input  logic            sample_valid,
    output logic            sample_req,
    output logic            sample_sel,
    output logic [7:0]      duty,
    output logic            duty_valid,
    output logic [2*DW-1:0] power_out,
    output logic            dir,
    output logic            busy
);
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SETTLE, S_REQ_V, S_REQ_I, S_CALC, S_UPDATE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   v_q, v_d, i_q, i_d;
    logic [2*DW-1:0] power_q, power_d, pprev_q, pprev_d;
    logic [7:0]      duty_q, duty_d;
    logic            dir_q, dir_d, first_q, first_d, dv_q, dv_d;
    logic            dir_eff;
    logic [8:0]      up_sum;

    // State and datapath registers; reset puts everything back to power-on values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            v_q     <= '0;
            i_q     <= '0;
            power_q <= '0;
            pprev_q <= '0;
            duty_q  <= 8'(DUTY_INIT);
            dir_q   <= 1'b1;
            first_q <= 1'b1;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            v_q     <= v_d;
            i_q     <= i_d;
            power_q <= power_d;
            pprev_q <= pprev_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            first_q <= first_d;
            dv_q    <= dv_d;
        end
    end

    // Next-state and update logic; dropping en abandons whatever was in flight
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        v_d     = v_q;
        i_d     = i_q;
        power_d = power_q;
        pprev_d = pprev_q;
        duty_d  = duty_q;
        dir_d   = dir_q;
        first_d = first_q;
        dv_d    = 1'b0;
        // The first pass after enable has no valid previous power to compare with
        dir_eff = (!first_q && (power_q < pprev_q)) ? ~dir_q : dir_q;
        up_sum  = {1'b0, duty_q} + 9'(STEP);
        if (!en) begin
            state_d = S_IDLE;
            first_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_SETTLE;
                    cnt_d   = CW'(SETTLE_CYC - 1);
                end
                S_SETTLE: begin
                    if (cnt_q == '0) state_d = S_REQ_V;
                    else             cnt_d   = cnt_q - 1'b1;
                end
                S_REQ_V: begin
                    if (sample_valid) begin
                        v_d     = sample_in;
                        state_d = S_REQ_I;
                    end
                end
                S_REQ_I: begin
                    if (sample_valid) begin
                        i_d     = sample_in;
                        state_d = S_CALC;
                    end
                end
                S_CALC: begin
                    power_d = {{DW{1'b0}}, v_q} * {{DW{1'b0}}, i_q};
                    state_d = S_UPDATE;
                end
                S_UPDATE: begin
                    // Hitting a clamp reverses direction so we bounce off the rail
                    if (dir_eff) begin
                        if (up_sum >= 9'(DUTY_MAX)) begin
                            duty_d = 8'(DUTY_MAX);
                            dir_d  = 1'b0;
                        end else begin
                            duty_d = up_sum[7:0];
                            dir_d  = 1'b1;
                        end
                    end else begin
                        if ({1'b0, duty_q} <= 9'(DUTY_MIN + STEP)) begin
                            duty_d = 8'(DUTY_MIN);
                            dir_d  = 1'b1;
                        end else begin
                            duty_d = duty_q - 8'(STEP);
                            dir_d  = 1'b0;
                        end
                    end
                    first_d = 1'b0;
                    pprev_d = power_q;
                    dv_d    = 1'b1;
                    cnt_d   = CW'(SETTLE_CYC - 1);
                    state_d = S_SETTLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign sample_req = (state_q == S_REQ_V) || (state_q == S_REQ_I);
    assign sample_sel = (state_q == S_REQ_I);
    assign busy       = (state_q != S_IDLE);
    assign duty       = duty_q;
    assign duty_valid = dv_q;
    assign power_out  = power_q;
    assign dir        = dir_q;
endmodule

// File: tb/tb_mppt_po_controller.sv
// Directed bench for mppt_po_controller with a scoreboard of expected updates.
module tb_mppt_po_controller;
    logic        clk = 1'b0;
    logic        rst, en, sample_valid;
    logic [7:0]  sample_in;
    logic        sample_req, sample_sel, duty_valid, dir, busy;
    logic [7:0]  duty;
    logic [15:0] power_out;

    mppt_po_controller #(.SETTLE_CYC(4)) dut (
        .clk(clk), .rst(rst), .en(en), .sample_in(sample_in),
        .sample_valid(sample_valid), .sample_req(sample_req),
        .sample_sel(sample_sel), .duty(duty), .duty_valid(duty_valid),
        .power_out(power_out), .dir(dir), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { int pow; int duty; int dir; } exp_t;
    exp_t sb[$];
    int n_cmp = 0, n_err = 0;
    int m_duty, m_dir, m_pprev, m_first;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_duty = 128; m_dir = 1; m_pprev = 0; m_first = 1;
    endtask

    // Reference P&O step: direction decision, clamped step, remember power
    task automatic push_model(input int v, input int i);
        exp_t e;
        int pow;
        pow = v * i;
        if (m_first == 0 && pow < m_pprev) m_dir = 1 - m_dir;
        m_first = 0;
        if (m_dir == 1) begin
            if (m_duty + 4 >= 240) begin m_duty = 240; m_dir = 0; end
            else m_duty = m_duty + 4;
        end else begin
            if (m_duty - 4 <= 16) begin m_duty = 16; m_dir = 1; end
            else m_duty = m_duty - 4;
        end
        m_pprev = pow;
        e.pow = pow; e.duty = m_duty; e.dir = m_dir;
        sb.push_back(e);
    endtask

    // Wait for a request of the given select; noise on sample_valid while idle
    task automatic wait_req(input bit sel, input bit serve, input int val, output bit ok);
        ok = 0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (sample_req === 1'b1 && sample_sel === sel) begin
                ok = 1;
                sample_in    = 8'(val);
                sample_valid = serve;
                break;
            end else begin
                sample_in    = 8'hEE;
                sample_valid = !sample_req;
            end
        end
    endtask

    task automatic do_pass(input int v, input int i);
        bit   ok;
        exp_t e;
        push_model(v, i);
        wait_req(1'b0, 1'b1, v, ok);
        check("req_v_seen", 32'(ok), 1);
        wait_req(1'b1, 1'b1, i, ok);
        check("req_i_seen", 32'(ok), 1);
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            sample_valid = 1'b0;
            if (duty_valid === 1'b1) begin ok = 1; break; end
        end
        check("duty_valid_seen", 32'(ok), 1);
        e = sb.pop_front();
        check("power_out", 32'(power_out), 32'(e.pow));
        check("duty", 32'(duty), 32'(e.duty));
        check("dir", 32'(dir), 32'(e.dir));
        @(negedge clk);
        check("duty_valid_pulse", 32'(duty_valid), 0);
    endtask

    initial begin
        bit ok;
        int dv_cnt;
        logic [7:0] duty_hold;
        rst = 1'b1; en = 1'b0; sample_valid = 1'b0; sample_in = '0;
        model_reset();
        repeat (3) @(negedge clk);
        // reset state
        check("rst_duty", 32'(duty), 128);
        check("rst_dir", 32'(dir), 1);
        check("rst_req", 32'(sample_req), 0);
        check("rst_dv", 32'(duty_valid), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_power", 32'(power_out), 0);
        rst = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        check("busy_on", 32'(busy), 1);

        // first pass, then rising and falling power
        do_pass(100, 50);
        check("t2_duty", 32'(duty), 132);
        do_pass(100, 60);
        check("t3_duty", 32'(duty), 136);
        do_pass(100, 40);
        check("t4_duty", 32'(duty), 132);
        check("t4_dir", 32'(dir), 0);

        // asynchronous reset while running
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_duty", 32'(duty), 128);
        check("midrst_dir", 32'(dir), 1);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_power", 32'(power_out), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // climb to the upper clamp on equal power (ties hold dir)
        do_pass(100, 50);
        for (int n = 0; n < 26; n++) do_pass(100, 50);
        check("t5_pre_duty", 32'(duty), 236);
        check("t5_pre_dir", 32'(dir), 1);
        do_pass(100, 60);
        check("t5_clamp_duty", 32'(duty), 240);
        check("t5_clamp_dir", 32'(dir), 0);
        do_pass(100, 70);
        check("t5_after_duty", 32'(duty), 236);

        // drop en while the current sample is being requested
        wait_req(1'b0, 1'b1, 100, ok);
        check("t6_req_v_seen", 32'(ok), 1);
        wait_req(1'b1, 1'b0, 0, ok);
        check("t6_req_i_seen", 32'(ok), 1);
        duty_hold = duty;
        en = 1'b0;
        sample_valid = 1'b0;
        @(negedge clk);
        check("t6_req_drop", 32'(sample_req), 0);
        check("t6_busy", 32'(busy), 0);
        dv_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (duty_valid === 1'b1) dv_cnt++;
        end
        check("t6_no_dv", 32'(dv_cnt), 0);
        check("t6_duty_held", 32'(duty), 32'(duty_hold));
        m_first = 1;
        en = 1'b1;
        do_pass(100, 50);
        check("t6_restart_duty", 32'(duty), 232);
        check("t6_restart_dir", 32'(dir), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
